// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A write to x0 is architecturally discarded, so it never matches a reader.
    function automatic logic reg_hit(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
        return wr && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX operand bypass select for one source register; EX_MEM has priority over MEM_WB.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic       regwr_mem,
    input  logic [4:0] rd_wb,
    input  logic       regwr_wb,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_hit(regwr_mem, rd_mem, rs)) begin
            sel = FWD_EXMEM;
        end else if (reg_hit(regwr_wb, rd_wb, rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/flush priority mux, data-memory wait FSM with timeout,
// operand forwarding selects and saturating stall/flush event counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic             regwr_ex,
    input  logic             is_load_ex,
    input  logic [4:0]       rd_mem,
    input  logic             regwr_mem,
    input  logic [4:0]       rd_wb,
    input  logic             regwr_wb,
    input  logic             pc_src_ex,
    input  logic             jalr_ex,
    input  logic             i_ready,
    input  logic             mem_req,
    input  logic             d_ready,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             flush_id,
    output logic             stall_ex,
    output logic             flush_ex,
    output logic             stall_mem,
    output logic             bubble_wb,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            lu_prev;
    logic            freeze;
    logic            redirect;
    logic            load_use;
    logic            redirect_take;
    logic            lu_take;
    logic [1:0]      fwd_a_raw;
    logic [1:0]      fwd_b_raw;

    fwd_unit u_fwd_a (
        .rs        (rs1_ex),
        .rd_mem    (rd_mem),
        .regwr_mem (regwr_mem),
        .rd_wb     (rd_wb),
        .regwr_wb  (regwr_wb),
        .sel       (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .rs        (rs2_ex),
        .rd_mem    (rd_mem),
        .regwr_mem (regwr_mem),
        .rd_wb     (rd_wb),
        .regwr_wb  (regwr_wb),
        .sel       (fwd_b_raw)
    );

    assign fwd_a = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b = rst ? FWD_RF : fwd_b_raw;

    // In MEM_WAIT a d_ready cycle releases the freeze immediately so lower rules can act.
    assign freeze = (state == ERR) ||
                    ((state == MEM_WAIT) && !d_ready) ||
                    ((state == RUN) && mem_req && !d_ready);

    assign redirect = pc_src_ex || jalr_ex;

    // lu_prev keeps a held load-use pair from stalling a second time.
    assign load_use = is_load_ex && regwr_ex && (rd_ex != REG_X0) && !lu_prev &&
                      ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));

    always_comb begin
        stall_pc      = 1'b0;
        stall_id      = 1'b0;
        flush_id      = 1'b0;
        stall_ex      = 1'b0;
        flush_ex      = 1'b0;
        stall_mem     = 1'b0;
        bubble_wb     = 1'b0;
        redirect_take = 1'b0;
        lu_take       = 1'b0;
        if (rst) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            bubble_wb = 1'b1;
        end else if (freeze) begin
            stall_pc  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
        end else if (redirect) begin
            flush_id      = 1'b1;
            flush_ex      = 1'b1;
            redirect_take = 1'b1;
        end else if (load_use) begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
            lu_take  = 1'b1;
        end else if (!i_ready) begin
            stall_pc = 1'b1;
            flush_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            to_cnt    <= '0;
            mem_err   <= 1'b0;
            lu_prev   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            lu_prev <= lu_take;
            if (stall_pc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_take && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (mem_req && !d_ready) begin
                        state  <= MEM_WAIT;
                        to_cnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (d_ready) begin
                        state  <= RUN;
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LIMIT) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (small counter width and timeout).
module tb_pipe_hazard_ctrl;

    localparam int CNT_W       = 6;
    localparam int TO_W        = 8;
    localparam int MEM_TIMEOUT = 12;

    // Control vector order: {stall_pc, stall_id, flush_id, stall_ex, flush_ex, stall_mem, bubble_wb}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_RST    = 7'b0010101;
    localparam logic [6:0] C_FREEZE = 7'b1101011;
    localparam logic [6:0] C_REDIR  = 7'b0010100;
    localparam logic [6:0] C_LU     = 7'b1100100;
    localparam logic [6:0] C_FETCH  = 7'b1010000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic use_rs1_id, use_rs2_id, regwr_ex, is_load_ex, regwr_mem, regwr_wb;
    logic pc_src_ex, jalr_ex, i_ready, mem_req, d_ready;
    logic stall_pc, stall_id, flush_id, stall_ex, flush_ex, stall_mem, bubble_wb;
    logic [1:0] fwd_a, fwd_b;
    logic mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        string      tag;
        logic [6:0] ctrl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       me;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    pipe_hazard_ctrl #(
        .CNT_W       (CNT_W),
        .TO_W        (TO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_id     (rs1_id),
        .rs2_id     (rs2_id),
        .use_rs1_id (use_rs1_id),
        .use_rs2_id (use_rs2_id),
        .rs1_ex     (rs1_ex),
        .rs2_ex     (rs2_ex),
        .rd_ex      (rd_ex),
        .regwr_ex   (regwr_ex),
        .is_load_ex (is_load_ex),
        .rd_mem     (rd_mem),
        .regwr_mem  (regwr_mem),
        .rd_wb      (rd_wb),
        .regwr_wb   (regwr_wb),
        .pc_src_ex  (pc_src_ex),
        .jalr_ex    (jalr_ex),
        .i_ready    (i_ready),
        .mem_req    (mem_req),
        .d_ready    (d_ready),
        .stall_pc   (stall_pc),
        .stall_id   (stall_id),
        .flush_id   (flush_id),
        .stall_ex   (stall_ex),
        .flush_ex   (flush_ex),
        .stall_mem  (stall_mem),
        .bubble_wb  (bubble_wb),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rs1_id = 5'd0; rs2_id = 5'd0; use_rs1_id = 1'b0; use_rs2_id = 1'b0;
        rs1_ex = 5'd0; rs2_ex = 5'd0; rd_ex = 5'd0; regwr_ex = 1'b0; is_load_ex = 1'b0;
        rd_mem = 5'd0; regwr_mem = 1'b0; rd_wb = 5'd0; regwr_wb = 1'b0;
        pc_src_ex = 1'b0; jalr_ex = 1'b0; i_ready = 1'b1; mem_req = 1'b0; d_ready = 1'b0;
    endtask

    // Pops the oldest expectation and compares it plus the counters against the reference model.
    task automatic checkOutput();
        exp_t e;
        logic [11:0] obs, req;
        e = sb.pop_front();
        obs = {stall_pc, stall_id, flush_id, stall_ex, flush_ex, stall_mem, bubble_wb, fwd_a, fwd_b, mem_err};
        req = {e.ctrl, e.fa, e.fb, e.me};
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("[TB] FAIL %s: observed ctrl/fa/fb/err=%b expected=%b", e.tag, obs, req);
        end
        checks++;
        assert (stall_cnt === m_stall) else begin
            errors++;
            $error("[TB] FAIL %s stall_cnt: observed=%0d expected=%0d", e.tag, stall_cnt, m_stall);
        end
        checks++;
        assert (flush_cnt === m_flush) else begin
            errors++;
            $error("[TB] FAIL %s flush_cnt: observed=%0d expected=%0d", e.tag, flush_cnt, m_flush);
        end
    endtask

    // Called at a falling edge with inputs already driven; consumes one clock cycle.
    task automatic applyStimulus(input string tag, input logic [6:0] ctrl,
                                 input logic [1:0] fa, input logic [1:0] fb, input logic me);
        exp_t e;
        e.tag = tag; e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.me = me;
        sb.push_back(e);
        #2;
        checkOutput();
        if (rst) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (ctrl[6] && (m_stall != '1)) m_stall = m_stall + 1'b1;
            if ((ctrl == C_REDIR) && (m_flush != '1)) m_flush = m_flush + 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);

        // Reset: forwarding forced to regfile even with a matching producer.
        regwr_mem = 1'b1; rd_mem = 5'd7; rs1_ex = 5'd7;
        applyStimulus("reset_a", C_RST, 2'b00, 2'b00, 1'b0);
        applyStimulus("reset_b", C_RST, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        idle();
        applyStimulus("idle", C_NONE, 2'b00, 2'b00, 1'b0);

        // T1 load-use
        is_load_ex = 1'b1; regwr_ex = 1'b1; rd_ex = 5'd5;
        rs1_id = 5'd5; use_rs1_id = 1'b1; rs2_id = 5'd1; use_rs2_id = 1'b1;
        applyStimulus("lu_stall", C_LU, 2'b00, 2'b00, 1'b0);
        applyStimulus("lu_one_cycle", C_NONE, 2'b00, 2'b00, 1'b0);
        idle();
        applyStimulus("lu_after", C_NONE, 2'b00, 2'b00, 1'b0);
        is_load_ex = 1'b1; regwr_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1'b1;
        applyStimulus("lu_rd_x0", C_NONE, 2'b00, 2'b00, 1'b0);
        rd_ex = 5'd9; rs1_id = 5'd2; rs2_id = 5'd9; use_rs2_id = 1'b0;
        applyStimulus("lu_rs2_unused", C_NONE, 2'b00, 2'b00, 1'b0);
        use_rs2_id = 1'b1;
        applyStimulus("lu_rs2", C_LU, 2'b00, 2'b00, 1'b0);
        idle();

        // T2 forwarding
        regwr_mem = 1'b1; rd_mem = 5'd7; regwr_wb = 1'b1; rd_wb = 5'd7; rs1_ex = 5'd7; rs2_ex = 5'd3;
        applyStimulus("fwd_exmem_wins", C_NONE, 2'b01, 2'b00, 1'b0);
        regwr_mem = 1'b0;
        applyStimulus("fwd_memwb", C_NONE, 2'b10, 2'b00, 1'b0);
        regwr_mem = 1'b1; rd_wb = 5'd4; rs2_ex = 5'd4;
        applyStimulus("fwd_both_ops", C_NONE, 2'b01, 2'b10, 1'b0);
        rd_mem = 5'd0; rd_wb = 5'd0; rs1_ex = 5'd0; rs2_ex = 5'd0;
        applyStimulus("fwd_x0", C_NONE, 2'b00, 2'b00, 1'b0);
        idle();

        // T3 redirect over load-use, jalr, fetch wait
        pc_src_ex = 1'b1;
        is_load_ex = 1'b1; regwr_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1'b1;
        applyStimulus("redir_over_lu", C_REDIR, 2'b00, 2'b00, 1'b0);
        idle();
        jalr_ex = 1'b1;
        applyStimulus("jalr", C_REDIR, 2'b00, 2'b00, 1'b0);
        idle();
        i_ready = 1'b0;
        applyStimulus("fetch_wait", C_FETCH, 2'b00, 2'b00, 1'b0);
        pc_src_ex = 1'b1;
        applyStimulus("redir_over_fetch", C_REDIR, 2'b00, 2'b00, 1'b0);
        idle();

        // T4 short memory wait with a redirect pending in the frozen EX
        mem_req = 1'b1; d_ready = 1'b0; pc_src_ex = 1'b1;
        regwr_mem = 1'b1; rd_mem = 5'd7; rs1_ex = 5'd7;
        for (int i = 0; i < 3; i++) begin
            applyStimulus("mem_freeze", C_FREEZE, 2'b01, 2'b00, 1'b0);
        end
        d_ready = 1'b1;
        applyStimulus("mem_release", C_REDIR, 2'b01, 2'b00, 1'b0);
        idle();
        applyStimulus("back_in_run", C_NONE, 2'b00, 2'b00, 1'b0);
        mem_req = 1'b1; d_ready = 1'b1;
        applyStimulus("mem_ready_now", C_NONE, 2'b00, 2'b00, 1'b0);
        idle();

        // T5 memory timeout and sticky error
        mem_req = 1'b1; d_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
            applyStimulus("mem_wait_to", C_FREEZE, 2'b00, 2'b00, 1'b0);
        end
        applyStimulus("mem_err_set", C_FREEZE, 2'b00, 2'b00, 1'b1);
        mem_req = 1'b0; d_ready = 1'b1;
        applyStimulus("err_held_a", C_FREEZE, 2'b00, 2'b00, 1'b1);
        applyStimulus("err_held_b", C_FREEZE, 2'b00, 2'b00, 1'b1);
        rst = 1'b1;
        applyStimulus("err_reset", C_RST, 2'b00, 2'b00, 1'b1);
        rst = 1'b0;
        idle();
        applyStimulus("after_reset", C_NONE, 2'b00, 2'b00, 1'b0);

        // T6 stall counter saturation
        i_ready = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 6; i++) begin
            applyStimulus("stall_sat", C_FETCH, 2'b00, 2'b00, 1'b0);
        end
        idle();
        #2;
        checks++;
        assert (stall_cnt === {CNT_W{1'b1}}) else begin
            errors++;
            $error("[TB] FAIL stall_cnt_saturated: observed=%0d expected=%0d", stall_cnt, {CNT_W{1'b1}});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
